// File: rtl/nib_serial_add16_if.sv
// nib_serial_add16_if: operand/result handshake plus the external 4-bit adder link.
interface nib_serial_add16_if;
  logic        start;
  logic        sub;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_ci;
  logic [3:0]  add_q;
  logic        add_co;
  modport master (output start, sub, op_a, op_b, add_q, add_co,
                  input  busy, done, result, carry, add_a, add_b, add_ci);
  modport slave  (input  start, sub, op_a, op_b, add_q, add_co,
                  output busy, done, result, carry, add_a, add_b, add_ci);
endinterface

// File: rtl/nib_serial_add16.sv
// nib_serial_add16: 16-bit add/subtract done one nibble per cycle through an external 4-bit adder.
module nib_serial_add16 (
  input logic              sys_clk,
  input logic              resetl,
  nib_serial_add16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state, state_nxt;
  logic [15:0] a_lat, b_lat, res;
  logic [1:0]  idx;
  logic        cr, cy, go, run;
  assign run = state == RUN;
  assign go  = bus.start && !run;
  always_comb begin
    state_nxt = go ? RUN : (run && idx == 2'd3) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) state <= IDLE;
    else state <= state_nxt;
  end
  // Subtraction is A + ~B + 1: invert B at latch time and seed the carry with sub.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      a_lat <= '0;
      b_lat <= '0;
      res   <= '0;
      idx   <= '0;
      cr    <= 1'b0;
      cy    <= 1'b0;
    end else if (go) begin
      a_lat <= bus.op_a;
      b_lat <= bus.sub ? ~bus.op_b : bus.op_b;
      cr    <= bus.sub;
      idx   <= '0;
    end else if (run) begin
      res[{idx, 2'b00} +: 4] <= bus.add_q;
      cr  <= bus.add_co;
      idx <= idx + 2'd1;
      if (idx == 2'd3) cy <= bus.add_co;
    end
  end
  assign bus.busy   = run;
  assign bus.done   = state == DONE;
  assign bus.result = res;
  assign bus.carry  = cy;
  assign bus.add_a  = run ? a_lat[{idx, 2'b00} +: 4] : 4'h0;
  assign bus.add_b  = run ? b_lat[{idx, 2'b00} +: 4] : 4'h0;
  assign bus.add_ci = run & cr;
endmodule
